// File: rtl/scan_pkg.sv
// Shared widths, frame geometry and FSM state type for the scan-out unloader.
package scan_pkg;

    localparam int unsigned SCAN_WORD_W = 26;
    localparam int unsigned SCAN_DEPTH  = 256;
    localparam int unsigned SCAN_ADDR_W = 8;
    localparam int unsigned FRAME_BITS  = SCAN_WORD_W * SCAN_DEPTH;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } scan_state_e;

endpackage

// File: rtl/scan_shift_lane.sv
// One serializer lane: parallel load, shift right toward bit 0, synchronous clear.
module scan_shift_lane #(
    parameter int unsigned WORD_W = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic              clear,
    input  logic [WORD_W-1:0] data,
    output logic              bit0
);

    logic [WORD_W-1:0] sr_q;

    // Clear wins over load so an abort or frame end always silences the lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (clear) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= data;
        end else if (shift) begin
            sr_q <= {1'b0, sr_q[WORD_W-1:1]};
        end
    end

    assign bit0 = sr_q[0];

endmodule

// File: rtl/scan_unloader.sv
// Walks the x buffer and w memory from the top address down, serializing each word
// LSB-first while holding the LMS core frozen for a consistent capture frame.
module scan_unloader
    import scan_pkg::*;
#(
    parameter int unsigned WORD_W = SCAN_WORD_W,
    parameter int unsigned DEPTH  = SCAN_DEPTH,
    parameter int unsigned ADDR_W = SCAN_ADDR_W
) (
    input  logic              scan_clk,
    input  logic              rst_n,
    input  logic              scan_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] x_rd_data,
    input  logic [WORD_W-1:0] w_rd_data,
    output logic              scan_out_x,
    output logic              scan_out_w,
    output logic              lms_freeze,
    output logic              scan_busy,
    output logic              scan_done
);

    localparam int unsigned BIT_W = $clog2(WORD_W);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);
    localparam logic [ADDR_W-1:0] TOP_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] NEXT_ADDR = ADDR_W'(DEPTH - 2);

    scan_state_e       state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic              armed_q, armed_d;
    logic              primed_q, primed_d;
    logic              freeze_d, busy_d, done_d;
    logic              lane_load, lane_shift, lane_clear;

    // Next-state, counter and address generation.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        rd_addr_d  = rd_addr;
        armed_d    = armed_q | ~scan_en;
        primed_d   = primed_q;
        freeze_d   = lms_freeze;
        busy_d     = scan_busy;
        done_d     = 1'b0;
        lane_load  = 1'b0;
        lane_shift = 1'b0;
        lane_clear = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Memory output reflects TOP_ADDR only after one idle edge has sampled it.
                rd_addr_d = TOP_ADDR;
                primed_d  = 1'b1;
                if (scan_en && armed_q && primed_q) begin
                    state_d    = SHIFT;
                    lane_load  = 1'b1;
                    rd_addr_d  = NEXT_ADDR;
                    bit_cnt_d  = '0;
                    word_cnt_d = TOP_ADDR;
                    freeze_d   = 1'b1;
                    busy_d     = 1'b1;
                    armed_d    = 1'b0;
                end
            end
            SHIFT: begin
                if (bit_cnt_q == LAST_BIT && word_cnt_q == '0) begin
                    // Final bit: completion takes priority over a simultaneous scan_en drop.
                    state_d    = IDLE;
                    lane_clear = 1'b1;
                    rd_addr_d  = TOP_ADDR;
                    bit_cnt_d  = '0;
                    word_cnt_d = TOP_ADDR;
                    freeze_d   = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    primed_d   = 1'b0;
                end else if (!scan_en) begin
                    state_d    = IDLE;
                    lane_clear = 1'b1;
                    rd_addr_d  = TOP_ADDR;
                    bit_cnt_d  = '0;
                    word_cnt_d = TOP_ADDR;
                    freeze_d   = 1'b0;
                    busy_d     = 1'b0;
                    primed_d   = 1'b0;
                end else if (bit_cnt_q != LAST_BIT) begin
                    lane_shift = 1'b1;
                    bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                end else begin
                    lane_load  = 1'b1;
                    bit_cnt_d  = '0;
                    word_cnt_d = word_cnt_q - ADDR_W'(1);
                    rd_addr_d  = (rd_addr == '0) ? '0 : rd_addr - ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            word_cnt_q <= TOP_ADDR;
            rd_addr    <= TOP_ADDR;
            armed_q    <= 1'b1;
            primed_q   <= 1'b0;
            lms_freeze <= 1'b0;
            scan_busy  <= 1'b0;
            scan_done  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            rd_addr    <= rd_addr_d;
            armed_q    <= armed_d;
            primed_q   <= primed_d;
            lms_freeze <= freeze_d;
            scan_busy  <= busy_d;
            scan_done  <= done_d;
        end
    end

    scan_shift_lane #(.WORD_W(WORD_W)) u_lane_x (
        .clk   (scan_clk),
        .rst_n (rst_n),
        .load  (lane_load),
        .shift (lane_shift),
        .clear (lane_clear),
        .data  (x_rd_data),
        .bit0  (scan_out_x)
    );

    scan_shift_lane #(.WORD_W(WORD_W)) u_lane_w (
        .clk   (scan_clk),
        .rst_n (rst_n),
        .load  (lane_load),
        .shift (lane_shift),
        .clear (lane_clear),
        .data  (w_rd_data),
        .bit0  (scan_out_w)
    );

endmodule

// File: tb/tb_scan_unloader.sv
// Directed bench for scan_unloader with a 1-cycle-latency x/w memory model.
module tb_scan_unloader;

    logic        scan_clk;
    logic        rst_n;
    logic        scan_en;
    logic [7:0]  rd_addr;
    logic [25:0] x_rd_data;
    logic [25:0] w_rd_data;
    logic        scan_out_x;
    logic        scan_out_w;
    logic        lms_freeze;
    logic        scan_busy;
    logic        scan_done;

    logic [25:0] mem_x [256];
    logic [25:0] mem_w [256];

    int n_tests = 0;
    int n_fail  = 0;

    scan_unloader dut (
        .scan_clk   (scan_clk),
        .rst_n      (rst_n),
        .scan_en    (scan_en),
        .rd_addr    (rd_addr),
        .x_rd_data  (x_rd_data),
        .w_rd_data  (w_rd_data),
        .scan_out_x (scan_out_x),
        .scan_out_w (scan_out_w),
        .lms_freeze (lms_freeze),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done)
    );

    initial begin
        scan_clk = 1'b0;
        forever #5 scan_clk = ~scan_clk;
    end

    // Synchronous read: data for the address sampled at an edge appears after that edge.
    always @(posedge scan_clk) begin
        x_rd_data <= mem_x[rd_addr];
        w_rd_data <= mem_w[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge scan_clk);
        #1;
    endtask

    task automatic fill_pattern();
        for (int a = 0; a < 256; a++) begin
            mem_x[a] = {18'h0, 8'(a)};
            mem_w[a] = 26'h2AAAAAA ^ {18'h0, 8'(a)};
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < 256; a++) begin
            mem_x[a] = 26'($urandom);
            mem_w[a] = 26'($urandom);
        end
    endtask

    // Launch a scan and capture a full frame, checking every word and the control window.
    task automatic run_frame(input string tag);
        logic [25:0] ax, aw;
        int bad_ctl, bad_addr;
        bad_ctl  = 0;
        bad_addr = 0;
        scan_en = 1'b0;
        tick();
        tick();
        check({tag, " pre_freeze"}, 32'(lms_freeze), 32'd0);
        scan_en = 1'b1;
        tick();
        for (int k = 0; k < 256; k++) begin
            ax = '0;
            aw = '0;
            for (int b = 0; b < 26; b++) begin
                ax[b] = scan_out_x;
                aw[b] = scan_out_w;
                if (lms_freeze !== 1'b1 || scan_busy !== 1'b1 || scan_done !== 1'b0)
                    bad_ctl++;
                if (k < 255 && b >= 24 && rd_addr !== 8'(254 - k))
                    bad_addr++;
                tick();
            end
            check($sformatf("%s x[%0d]", tag, k), 32'(ax), 32'(mem_x[255 - k]));
            check($sformatf("%s w[%0d]", tag, k), 32'(aw), 32'(mem_w[255 - k]));
        end
        check({tag, " done_pulse"}, 32'(scan_done), 32'd1);
        check({tag, " freeze_end"}, 32'(lms_freeze), 32'd0);
        check({tag, " busy_end"}, 32'(scan_busy), 32'd0);
        check({tag, " addr_end"}, 32'(rd_addr), 32'd255);
        check({tag, " outs_end"}, {30'd0, scan_out_x, scan_out_w}, 32'd0);
        check({tag, " ctl_window"}, 32'(bad_ctl), 32'd0);
        check({tag, " addr_prefetch"}, 32'(bad_addr), 32'd0);
        tick();
        check({tag, " done_one_cycle"}, 32'(scan_done), 32'd0);
    endtask

    initial begin
        int extra;
        rst_n   = 1'b0;
        scan_en = 1'b0;
        fill_pattern();
        tick();
        tick();
        check("rst addr", 32'(rd_addr), 32'd255);
        check("rst outs", {30'd0, scan_out_x, scan_out_w}, 32'd0);
        check("rst ctl", {29'd0, lms_freeze, scan_busy, scan_done}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Frame with scan_en held high well past completion: no second frame.
        run_frame("pat1");
        extra = 0;
        for (int i = 0; i < 13300; i++) begin
            if (scan_busy || scan_done || lms_freeze) extra++;
            tick();
        end
        check("hold_no_restart", 32'(extra), 32'd0);
        run_frame("pat2");

        // Abort at bit 5 of word 3 (address 252).
        scan_en = 1'b0;
        tick();
        tick();
        scan_en = 1'b1;
        tick();
        repeat (83) tick();
        check("abort pre_bit_x", 32'(scan_out_x), 32'(mem_x[252][5]));
        check("abort pre_bit_w", 32'(scan_out_w), 32'(mem_w[252][5]));
        scan_en = 1'b0;
        tick();
        check("abort outs", {30'd0, scan_out_x, scan_out_w}, 32'd0);
        check("abort addr", 32'(rd_addr), 32'd255);
        check("abort ctl", {29'd0, lms_freeze, scan_busy, scan_done}, 32'd0);
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            if (scan_done) extra++;
            tick();
        end
        check("abort no_done", 32'(extra), 32'd0);
        run_frame("restart");

        // Asynchronous reset 3000 cycles into a scan, then a random-content frame.
        scan_en = 1'b0;
        tick();
        tick();
        scan_en = 1'b1;
        tick();
        repeat (3000) tick();
        check("midscan busy", 32'(scan_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst addr", 32'(rd_addr), 32'd255);
        check("midrst outs", {30'd0, scan_out_x, scan_out_w}, 32'd0);
        check("midrst ctl", {29'd0, lms_freeze, scan_busy, scan_done}, 32'd0);
        scan_en = 1'b0;
        tick();
        rst_n = 1'b1;
        fill_random();
        tick();
        run_frame("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
